// File: rtl/subtractor_32_bit_serial.sv
// rtl/subtractor_32_bit_serial.sv - bit-serial a - b - borrow_in, LSB first, start/done handshake
module subtractor_32_bit_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] acc_next;

  // Single full-subtractor cell; the result bit enters the accumulator at the MSB.
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    acc_next = {d, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      acc        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= borrow_in;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Shift registers have lost the operand MSBs; use the copies taken at acceptance.
            diff       <= acc_next;
            borrow_out <= br_next;
            overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
            zero       <= (acc_next == '0);
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_32_bit_serial.sv
// tb/tb_subtractor_32_bit_serial.sv - randomized self-checking bench against an arithmetic model
module tb_subtractor_32_bit_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        borrow_in;
  logic [31:0] diff;
  logic        borrow_out;
  logic        overflow;
  logic        zero;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  subtractor_32_bit_serial #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .zero(zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {zero, overflow, borrow_out, diff}
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    logic [32:0] full;
    logic        ovf;
    full = {1'b0, ma} - {1'b0, mb} - {32'd0, mbin};
    ovf  = (ma[31] != mb[31]) && (full[31] != ma[31]);
    return {full[31:0] == 32'd0, ovf, full[32], full[31:0]};
  endfunction

  task automatic start_op(input logic [31:0] oa, input logic [31:0] ob, input logic obin);
    a = oa; b = ob; borrow_in = obin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  // Waits for done; optionally throws new start requests at the accepted op while it runs.
  task automatic wait_done(input bit inject, input logic [31:0] held_diff);
    int lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (inject && (i == 5 || i == 32)) begin
        start = 1'b1; a = $urandom; b = $urandom; borrow_in = 1'($urandom);
      end else begin
        start = 1'b0; a = $urandom; b = $urandom; borrow_in = 1'($urandom);
      end
      @(posedge clk); #1;
      if (i == 10) check("diff_hold_during_run", diff, held_diff);
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    check("latency", lat, 32);
  endtask

  task automatic check_result(input logic [31:0] oa, input logic [31:0] ob, input logic obin);
    logic [34:0] m;
    m = model(oa, ob, obin);
    check("diff", diff, m[31:0]);
    check("borrow_out", borrow_out, m[32]);
    check("overflow", overflow, m[33]);
    check("zero", zero, m[34]);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
  endtask

  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic obin, input bit inject);
    logic [31:0] prev;
    prev = diff;
    start_op(oa, ob, obin);
    wait_done(inject, prev);
    check_result(oa, ob, obin);
    @(posedge clk); #1;
    check("done_fall", done, 0);
    check("busy_fall", busy, 0);
  endtask

  initial begin
    int          dcount;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbin;

    reset = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    #12;
    check("rst_diff", diff, 0);
    check("rst_flags", {28'd0, borrow_out, overflow, zero, busy}, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0);

    // Zero flag, then hold through idle with no further done pulses
    run_op(32'h0000_003F, 32'h0000_003F, 1'b0, 1'b0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("idle_done_count", dcount, 0);
    check("hold_diff", diff, 0);
    check("hold_zero", zero, 1);

    // Start requests during RUN are ignored
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);

    // Back-to-back: start held from the DONE cycle is accepted only at E34
    start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
    wait_done(1'b0, 32'hFFFF_FFFF - 32'h0BAD_F00D + 32'hDEAD_BEEF);
    check_result(32'h0000_0010, 32'h0000_0020, 1'b0);
    a = 32'h0000_0100; b = 32'h0000_0001; borrow_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("ignored_in_done", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("accepted_e34", busy, 1);
    wait_done(1'b0, 32'hFFFF_FFF0);
    check_result(32'h0000_0100, 32'h0000_0001, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset mid-run
    start_op(32'hCAFE_0000, 32'h0000_1234, 1'b1);
    for (int i = 0; i < 11; i++) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_diff", diff, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_flags", {29'd0, borrow_out, overflow, zero}, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    check("no_done_after_abort", dcount, 0);
    run_op(32'd5, 32'd7, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom);
      if (n % 5 == 0) rb = ra;
      run_op(ra, rb, rbin, n % 3 == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
